// File: rtl/mem_issue_pkg.sv
// Shared CPU constants for the memory-issue stage.
//   F3_*            : funct3 access-width encodings (bits [1:0]); bit 2 marks
//                     an unsigned (zero-extending) load.
//   mem_state_e     : state encoding of the sub-word store sequencer.
package mem_issue_pkg;

  localparam logic [1:0]  F3_BYTE         = 2'b00;
  localparam logic [1:0]  F3_HALF         = 2'b01;
  localparam logic [1:0]  F3_WORD         = 2'b10;
  localparam int unsigned F3_UNSIGNED_BIT = 2;

  typedef enum logic {
    ST_RUN = 1'b0,
    ST_RMW = 1'b1
  } mem_state_e;

endpackage

// File: rtl/mem_issue.sv
// Memory-issue stage: holds the M-stage register, presents loads/stores to
// memory, stretches sub-word stores over two cycles (read-modify-write in the
// memory), traps misaligned accesses and feeds the W-stage register.
//
// Ports
//   cpu_clk, rst              : clock (rising edge), synchronous active-high reset
//   ex_valid/load/store       : EX-side op qualifiers (load wins if both set)
//   ex_type                   : funct3 of the access
//   ex_addr, ex_data          : effective address and store data
//   ex_alu, ex_rd, ex_wen     : non-memory result, destination, write enable
//   flush                     : kill the op currently offered by EX
//   ex_ready                  : M register accepts a new op this cycle
//   sig_load, sig_store       : memory strobes
//   mem_type, addr, data      : memory access width, address, store data
//   mem_q                     : load data, valid the cycle after sig_load
//   mem_stall                 : memory busy with the second store cycle
//   wb_valid/rd/wen/data      : write-back port
//   misalign_exc/addr         : one-cycle trap pulse and sticky faulting address
module mem_issue
  import mem_issue_pkg::*;
#(
  parameter int MISALIGN_CHK = 1
) (
  input  logic        cpu_clk,
  input  logic        rst,
  input  logic        ex_valid,
  input  logic        ex_load,
  input  logic        ex_store,
  input  logic [2:0]  ex_type,
  input  logic [31:0] ex_addr,
  input  logic [31:0] ex_data,
  input  logic [31:0] ex_alu,
  input  logic [4:0]  ex_rd,
  input  logic        ex_wen,
  input  logic        flush,
  output logic        ex_ready,
  output logic        sig_load,
  output logic        sig_store,
  output logic [2:0]  mem_type,
  output logic [31:0] addr,
  output logic [31:0] data,
  input  logic [31:0] mem_q,
  input  logic        mem_stall,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic        wb_wen,
  output logic [31:0] wb_data,
  output logic        misalign_exc,
  output logic [31:0] misalign_addr
);

  function automatic logic misaligned(input logic [1:0] width, input logic [1:0] lsb);
    logic bad;
    bad = 1'b0;
    if (MISALIGN_CHK != 0) begin
      if (width == F3_HALF)      bad = lsb[0];
      else if (width == F3_WORD) bad = (lsb != 2'b00);
    end
    return bad;
  endfunction

  mem_state_e  state;

  logic        vld_p1;
  logic        load_p1;
  logic        store_p1;
  logic [2:0]  type_p1;
  logic [31:0] addr_p1;
  logic [31:0] data_p1;
  logic [31:0] alu_p1;
  logic [4:0]  rd_p1;
  logic        wen_p1;

  logic        vld_p2;
  logic        load_p2;
  logic [31:0] alu_p2;
  logic [4:0]  rd_p2;
  logic        wen_p2;
  logic        exc_p2;
  logic [31:0] exc_addr_p2;

  logic        mis;
  logic        sub_word;
  logic        hold;

  // Only memory ops are checked; ALU ops carry an arbitrary type/address.
  assign mis       = (load_p1 | store_p1) & misaligned(type_p1[1:0], addr_p1[1:0]);
  assign sig_load  = vld_p1 & load_p1 & ~mis;
  assign sig_store = vld_p1 & store_p1 & ~mis;
  assign sub_word  = (type_p1[1:0] != F3_WORD);
  // First cycle of a sub-word store: freeze M so the store is seen twice.
  assign hold      = (state == ST_RUN) & sig_store & sub_word;
  assign ex_ready  = ~hold;

  assign mem_type  = type_p1;
  assign addr      = addr_p1;
  assign data      = data_p1;

  // ---- EX -> M boundary ----
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      load_p1  <= 1'b0;
      store_p1 <= 1'b0;
      type_p1  <= '0;
      addr_p1  <= '0;
      data_p1  <= '0;
      alu_p1   <= '0;
      rd_p1    <= '0;
      wen_p1   <= 1'b0;
    end else if (!hold) begin
      vld_p1   <= ex_valid & ~flush;
      load_p1  <= ex_load;
      store_p1 <= ex_store & ~ex_load;
      type_p1  <= ex_type;
      addr_p1  <= ex_addr;
      data_p1  <= ex_data;
      alu_p1   <= ex_alu;
      rd_p1    <= ex_rd;
      wen_p1   <= ex_wen;
    end
  end

  // RMW always lasts exactly one cycle; flush cannot cut it short.
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      state <= ST_RUN;
    end else begin
      case (state)
        ST_RUN:  if (sig_store && sub_word) state <= ST_RMW;
        ST_RMW:  state <= ST_RUN;
        default: state <= ST_RUN;
      endcase
    end
  end

  // ---- M -> W boundary ----
  always_ff @(posedge cpu_clk) begin
    if (rst) begin
      vld_p2      <= 1'b0;
      load_p2     <= 1'b0;
      alu_p2      <= '0;
      rd_p2       <= '0;
      wen_p2      <= 1'b0;
      exc_p2      <= 1'b0;
      exc_addr_p2 <= '0;
    end else begin
      vld_p2  <= vld_p1 & ~mis & ~hold;
      load_p2 <= load_p1;
      alu_p2  <= alu_p1;
      rd_p2   <= rd_p1;
      wen_p2  <= wen_p1 & ~store_p1;
      exc_p2  <= vld_p1 & mis;
      if (vld_p1 && mis) exc_addr_p2 <= addr_p1;
    end
  end

  assign wb_valid      = vld_p2;
  assign wb_rd         = rd_p2;
  assign wb_wen        = wen_p2;
  assign wb_data       = load_p2 ? mem_q : alu_p2;
  assign misalign_exc  = exc_p2;
  assign misalign_addr = exc_addr_p2;

  // The memory must report the second store cycle as stalled; observation only.
  a_rmw_stall : assert property (@(posedge cpu_clk) disable iff (rst)
                                 (state == ST_RMW) == mem_stall);

endmodule

// File: tb/tb_mem_issue.sv
module tb_mem_issue;
  import mem_issue_pkg::*;

  localparam logic [2:0] LB  = 3'b000;
  localparam logic [2:0] LH  = 3'b001;
  localparam logic [2:0] LW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;

  logic cpu_clk = 1'b0;
  always #5 cpu_clk = ~cpu_clk;

  logic        rst;
  logic        ex_valid, ex_load, ex_store, ex_wen, flush;
  logic [2:0]  ex_type;
  logic [31:0] ex_addr, ex_data, ex_alu;
  logic [4:0]  ex_rd;

  logic        ex_ready, sig_load, sig_store, wb_valid, wb_wen, misalign_exc;
  logic [2:0]  mem_type;
  logic [31:0] addr, data, wb_data, misalign_addr;
  logic [4:0]  wb_rd;
  logic [31:0] mem_q = '0;
  logic        mem_stall = 1'b0;

  logic        n_ex_ready, n_sig_load, n_sig_store, n_wb_valid, n_wb_wen, n_misalign_exc;
  logic [2:0]  n_mem_type;
  logic [31:0] n_addr, n_data, n_wb_data, n_misalign_addr;
  logic [4:0]  n_wb_rd;
  logic        n_mem_stall = 1'b0;

  mem_issue #(.MISALIGN_CHK(1)) dut0 (
    .cpu_clk(cpu_clk), .rst(rst), .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_type(ex_type), .ex_addr(ex_addr), .ex_data(ex_data), .ex_alu(ex_alu), .ex_rd(ex_rd),
    .ex_wen(ex_wen), .flush(flush), .ex_ready(ex_ready), .sig_load(sig_load),
    .sig_store(sig_store), .mem_type(mem_type), .addr(addr), .data(data), .mem_q(mem_q),
    .mem_stall(mem_stall), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_wen(wb_wen),
    .wb_data(wb_data), .misalign_exc(misalign_exc), .misalign_addr(misalign_addr));

  mem_issue #(.MISALIGN_CHK(0)) dut1 (
    .cpu_clk(cpu_clk), .rst(rst), .ex_valid(ex_valid), .ex_load(ex_load), .ex_store(ex_store),
    .ex_type(ex_type), .ex_addr(ex_addr), .ex_data(ex_data), .ex_alu(ex_alu), .ex_rd(ex_rd),
    .ex_wen(ex_wen), .flush(flush), .ex_ready(n_ex_ready), .sig_load(n_sig_load),
    .sig_store(n_sig_store), .mem_type(n_mem_type), .addr(n_addr), .data(n_data),
    .mem_q(mem_q), .mem_stall(n_mem_stall), .wb_valid(n_wb_valid), .wb_rd(n_wb_rd),
    .wb_wen(n_wb_wen), .wb_data(n_wb_data), .misalign_exc(n_misalign_exc),
    .misalign_addr(n_misalign_addr));

  // Memory model: byte-lane merge on store, sign/zero extension on load.
  logic [31:0] mem [0:1023] = '{default: '0};

  function automatic logic [31:0] st_merge(input logic [31:0] old, input logic [31:0] d,
                                           input logic [2:0] t, input logic [1:0] a);
    logic [31:0] r;
    r = old;
    case (t[1:0])
      F3_BYTE: r[8*a +: 8] = d[7:0];
      F3_HALF: r[16*a[1] +: 16] = d[15:0];
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] ld_val(input logic [31:0] w, input logic [2:0] t,
                                         input logic [1:0] a);
    logic [31:0] sh;
    logic [31:0] r;
    sh = w >> (8*a);
    case (t[1:0])
      F3_BYTE: r = t[F3_UNSIGNED_BIT] ? {24'b0, sh[7:0]} : {{24{sh[7]}}, sh[7:0]};
      F3_HALF: r = t[F3_UNSIGNED_BIT] ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
      default: r = w;
    endcase
    return r;
  endfunction

  always @(posedge cpu_clk) begin
    if (sig_store) mem[addr[11:2]] <= st_merge(mem[addr[11:2]], data, mem_type, addr[1:0]);
    if (sig_load)  mem_q <= ld_val(mem[addr[11:2]], mem_type, addr[1:0]);
    if (rst) begin
      mem_stall   <= 1'b0;
      n_mem_stall <= 1'b0;
    end else begin
      mem_stall   <= sig_store && (mem_type[1:0] != F3_WORD) && !mem_stall;
      n_mem_stall <= n_sig_store && (n_mem_type[1:0] != F3_WORD) && !n_mem_stall;
    end
  end

  // Scoreboard
  typedef struct { logic st; logic [31:0] a; logic [31:0] d; logic [2:0] t; } mem_exp_t;
  typedef struct { logic [4:0] rd; logic wen; logic [31:0] d; logic ld; } wb_exp_t;
  mem_exp_t    mq[$];
  wb_exp_t     wq[$];
  logic [31:0] xq[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_load_cyc = -10;
  int stall_cnt = 0;
  int nochk_seen = 0;
  int nochk_exc = 0;

  always @(posedge cpu_clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic unexpected(input string name, input logic [31:0] act);
    checks++;
    errors++;
    $display("FAIL %s: got event with value %h, expected none", name, act);
  endtask

  // Monitor: pops and compares whenever the DUT presents something.
  always @(negedge cpu_clk) begin
    if (!rst) begin
      if (!ex_ready) stall_cnt++;
      if (wb_valid) begin
        if (wq.size() == 0) unexpected("wb_event", {27'b0, wb_rd});
        else begin
          wb_exp_t e;
          e = wq.pop_front();
          chk("wb_rd", {27'b0, wb_rd}, {27'b0, e.rd});
          chk("wb_wen", {31'b0, wb_wen}, {31'b0, e.wen});
          chk("wb_data", wb_data, e.d);
          if (e.ld) chk("load_latency", cyc, last_load_cyc + 1);
        end
      end
      if (sig_load || sig_store) begin
        if (mq.size() == 0) unexpected("mem_event", addr);
        else begin
          mem_exp_t m;
          m = mq.pop_front();
          chk("mem_kind", {30'b0, sig_load, sig_store}, m.st ? 32'd1 : 32'd2);
          chk("mem_addr", addr, m.a);
          chk("mem_type", {29'b0, mem_type}, {29'b0, m.t});
          if (m.st) chk("mem_data", data, m.d);
        end
      end
      if (sig_load) last_load_cyc = cyc;
      if (misalign_exc) begin
        if (xq.size() == 0) unexpected("exc_event", misalign_addr);
        else chk("exc_addr", misalign_addr, xq.pop_front());
      end
      if (n_sig_load && n_addr == 32'h103) nochk_seen++;
      if (n_misalign_exc) nochk_exc++;
    end
  end

  task automatic push_mem(input logic st, input logic [31:0] a, input logic [31:0] d,
                          input logic [2:0] t);
    mem_exp_t m;
    m.st = st; m.a = a; m.d = d; m.t = t;
    mq.push_back(m);
  endtask

  task automatic push_wb(input logic [4:0] rd, input logic wen, input logic [31:0] d,
                         input logic ld);
    wb_exp_t e;
    e.rd = rd; e.wen = wen; e.d = d; e.ld = ld;
    wq.push_back(e);
  endtask

  // Offers one op from EX until accepted; returns just after the accepting edge.
  task automatic send(input logic ld, input logic st, input logic [2:0] t,
                      input logic [31:0] a, input logic [31:0] d, input logic [31:0] alu,
                      input logic [4:0] rd, input logic wen, input logic fl);
    logic rdy;
    int n;
    ex_valid = 1'b1; ex_load = ld; ex_store = st; ex_type = t; ex_addr = a;
    ex_data = d; ex_alu = alu; ex_rd = rd; ex_wen = wen; flush = fl;
    n = 0;
    do begin
      @(negedge cpu_clk);
      rdy = ex_ready;
      @(posedge cpu_clk);
      n++;
    end while (!rdy && n < 8);
    if (!rdy) unexpected("send_timeout", a);
    #1;
    ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; flush = 1'b0;
  endtask

  task automatic do_store(input logic [2:0] t, input logic [31:0] a, input logic [31:0] d);
    push_mem(1'b1, a, d, t);
    if (t[1:0] != F3_WORD) push_mem(1'b1, a, d, t);
    push_wb(5'd0, 1'b0, 32'h0, 1'b0);
    send(1'b0, 1'b1, t, a, d, 32'h0, 5'd0, 1'b1, 1'b0);
  endtask

  task automatic do_load(input logic [2:0] t, input logic [31:0] a, input logic [4:0] rd,
                         input logic [31:0] expv);
    push_mem(1'b0, a, 32'h0, t);
    push_wb(rd, 1'b1, expv, 1'b1);
    send(1'b1, 1'b0, t, a, 32'h0, 32'hBAD0BAD0, rd, 1'b1, 1'b0);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ctl"}, {19'b0, sig_load, sig_store, mem_type, wb_valid, wb_rd, wb_wen,
                        misalign_exc}, 32'h0);
    chk({tag, "_addr"}, addr, 32'h0);
    chk({tag, "_data"}, data, 32'h0);
    chk({tag, "_wb_data"}, wb_data, 32'h0);
    chk({tag, "_misalign_addr"}, misalign_addr, 32'h0);
    chk({tag, "_ex_ready"}, {31'b0, ex_ready}, 32'h1);
    chk({tag, "_state"}, 32'(dut0.state), 32'(ST_RUN));
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int s0;
    rst = 1'b1; ex_valid = 1'b0; ex_load = 1'b0; ex_store = 1'b0; ex_type = '0;
    ex_addr = '0; ex_data = '0; ex_alu = '0; ex_rd = '0; ex_wen = 1'b0; flush = 1'b0;
    repeat (3) @(posedge cpu_clk);
    #1 rst = 1'b0;
    @(negedge cpu_clk);
    check_idle("reset");
    @(posedge cpu_clk); #1;

    // Word store: no stall; following load returns the word.
    s0 = stall_cnt;
    do_store(LW, 32'h100, 32'hDEADBEEF);
    do_load(LW, 32'h100, 5'd1, 32'hDEADBEEF);
    chk("sw_stall_cycles", stall_cnt - s0, 32'd0);

    // Byte store stretched to two cycles; back-to-back load delayed by one.
    s0 = stall_cnt;
    do_store(LB, 32'h101, 32'h000000A5);
    do_load(LW, 32'h100, 5'd2, 32'hDEADA5EF);
    chk("sb_stall_cycles", stall_cnt - s0, 32'd1);

    // Half loads: aligned, then misaligned (trapped, no memory, no writeback).
    do_load(LH, 32'h102, 5'd3, 32'hFFFFDEAD);
    xq.push_back(32'h103);
    send(1'b1, 1'b0, LH, 32'h103, 32'h0, 32'h0, 5'd4, 1'b1, 1'b0);

    // Flush while the byte store is in its RMW cycle.
    do_store(LB, 32'h200, 32'h0000005A);
    send(1'b1, 1'b0, LW, 32'h100, 32'h0, 32'h0, 5'd10, 1'b1, 1'b1);
    do_load(LW, 32'h200, 5'd11, 32'h0000005A);

    // ALU result then signed / unsigned byte loads of 0x80.
    do_store(LB, 32'h205, 32'h00000080);
    push_wb(5'd5, 1'b1, 32'h00001234, 1'b0);
    send(1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 32'h00001234, 5'd5, 1'b1, 1'b0);
    do_load(LB, 32'h205, 5'd6, 32'hFFFFFF80);
    do_load(LBU, 32'h205, 5'd7, 32'h00000080);

    // Load and store both set behaves as a load.
    push_mem(1'b0, 32'h100, 32'h0, LW);
    push_wb(5'd12, 1'b1, 32'hDEADA5EF, 1'b1);
    send(1'b1, 1'b1, LW, 32'h100, 32'h11111111, 32'hBAD0BAD0, 5'd12, 1'b1, 1'b0);

    // Misaligned word store: trapped, address stays visible afterwards.
    xq.push_back(32'h202);
    send(1'b0, 1'b1, LW, 32'h202, 32'hCAFEF00D, 32'h0, 5'd0, 1'b1, 1'b0);
    repeat (4) @(posedge cpu_clk);
    #1;
    chk("exc_addr_hold", misalign_addr, 32'h202);

    // Reset while a byte store sits in RMW, with a load waiting in EX.
    do_load(LW, 32'h100, 5'd8, 32'hDEADA5EF);
    push_mem(1'b1, 32'h300, 32'h00000077, LB);
    send(1'b0, 1'b1, LB, 32'h300, 32'h00000077, 32'h0, 5'd0, 1'b1, 1'b0);
    @(posedge cpu_clk); #1;
    chk("rmw_state", 32'(dut0.state), 32'(ST_RMW));
    rst = 1'b1;
    ex_valid = 1'b1; ex_load = 1'b1; ex_type = LW; ex_addr = 32'h100; ex_rd = 5'd9;
    @(posedge cpu_clk); #1;
    rst = 1'b0; ex_valid = 1'b0; ex_load = 1'b0;
    @(negedge cpu_clk);
    check_idle("mid_reset");
    @(posedge cpu_clk); #1;
    do_load(LW, 32'h100, 5'd13, 32'hDEADA5EF);

    repeat (5) @(posedge cpu_clk);
    #1;
    chk("mem_queue_empty", mq.size(), 32'd0);
    chk("wb_queue_empty", wq.size(), 32'd0);
    chk("exc_queue_empty", xq.size(), 32'd0);
    chk("nochk_load_issued", nochk_seen, 32'd1);
    chk("nochk_no_exc", nochk_exc, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
